// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg: FSM state and owner encodings shared by the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_DONE   = 2'd2,
    ST_UNUSED = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_lat_timer.sv
// ============================================================================
// mem_lat_timer: loadable down-counter that flags when it reaches zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Counter parks at zero until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one fixed-latency memory between fetch and data.
// Optional FAIR_ARB_EN: alternate grants on contention instead of DATA priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W    = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  arb_state_e        state_q,    state_d;
  owner_e            owner_q,    owner_d;
  logic              we_q,       we_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
  logic              timer_load;
  logic              cnt_zero;
  owner_e            grant_owner;

`ifdef FAIR_ARB_EN
  owner_e last_q, last_d;
`endif

  // DATA wins a tie by default; the fair build hands a tie to whoever was not served last.
  always_comb begin
    grant_owner = OWN_DATA;
    if (if_req && !d_req) begin
      grant_owner = OWN_IF;
`ifdef FAIR_ARB_EN
    end else if (if_req && d_req && (last_q == OWN_DATA)) begin
      grant_owner = OWN_IF;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    timer_load = 1'b0;
`ifdef FAIR_ARB_EN
    last_d     = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          state_d    = ST_BUSY;
          owner_d    = grant_owner;
          timer_load = 1'b1;
`ifdef FAIR_ARB_EN
          last_d     = grant_owner;
`endif
          if (grant_owner == OWN_DATA) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
          if (!we_q) begin
            if (owner_q == OWN_IF) begin
              if_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = mem_rdata;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_DATA;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

`ifdef FAIR_ARB_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_DATA;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  mem_lat_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (LOAD_VAL),
    .zero  (cnt_zero)
  );

  assign mem_en    = (state_q == ST_BUSY);
  assign mem_we    = (state_q == ST_BUSY) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == ST_DONE) && (owner_q == OWN_IF);
  assign d_ack     = (state_q == ST_DONE) && (owner_q == OWN_DATA);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req && !if_ack;
  assign d_stall   = d_req && !d_ack;

endmodule

`default_nettype wire
